// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes and FSM state type for the 16-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/dec_4_16.sv
// dec_4_16: 4-to-16 one-hot decoder.
module dec_4_16 (
    input  logic [3:0]  idx,
    output logic [15:0] dec
);
    assign dec = 16'd1 << idx;
endmodule

// File: rtl/rr_pick_16.sv
// rr_pick_16: first set request at or after ptr, searching upward with wrap.
module rr_pick_16 import arb_pkg::*; (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
    end
    assign any  = |req;
    assign pick = ptr + off;
endmodule

// File: rtl/rr_arb_16.sv
// rr_arb_16: round-robin arbiter with bounded hold; owner index is registered
// and expanded to a one-hot grant so req never reaches gnt combinationally.
module rr_arb_16 import arb_pkg::*; #(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, idx_n, pick, pick_ptr;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic             valid_n, any, rel;
    logic [N_REQ-1:0] dec;

    // On release the search starts just past the owner, giving it lowest priority.
    assign pick_ptr = (state == BUSY) ? gnt_idx + IDX_W'(1) : ptr;
    assign rel      = !req[gnt_idx] || hold_cnt == LAST;

    rr_pick_16 u_pick (.req(req), .ptr(pick_ptr), .pick(pick), .any(any));
    dec_4_16   u_dec  (.idx(gnt_idx), .dec(dec));

    assign gnt = dec & {N_REQ{gnt_valid}};

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        valid_n = gnt_valid;
        hold_n  = hold_cnt;
        if (state == IDLE) begin
            if (any) begin
                idx_n   = pick;
                valid_n = 1'b1;
                hold_n  = '0;
                state_n = BUSY;
            end
        end else if (rel) begin
            ptr_n  = pick_ptr;
            hold_n = '0;
            if (any) idx_n = pick;
            else begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        end else hold_n = hold_cnt + HW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
            hold_cnt  <= hold_n;
        end
    end
endmodule

// File: tb/tb_rr_arb_16.sv
// tb_rr_arb_16: directed literal checks plus randomized traffic against a
// behavioural owner/counter/pointer model of the arbiter.
module tb_rr_arb_16;
    localparam int MH = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] req = '0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;

    rr_arb_16 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++)
            if (r[(p + k) % 16]) return (p + k) % 16;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = search(req, m_ptr);
                m_cnt   = 0;
            end
        end else if (!req[m_owner] || m_cnt == MH - 1) begin
            m_ptr   = (m_owner + 1) % 16;
            m_owner = search(req, m_ptr);
            m_cnt   = 0;
        end else m_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
        chk("model_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
        chk("onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
        if (m_owner >= 0) begin
            chk("model_idx", int'(gnt_idx), m_owner);
            chk("model_hold", int'(dut.hold_cnt), m_cnt);
        end
    end

    task automatic cyc(input logic r, input logic [15:0] q);
        rst = r;
        req = q;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cyc(1, 16'hFFFF);
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_valid", int'(gnt_valid), 0);
            chk("rst_idx", int'(gnt_idx), 0);
        end
        cyc(0, 16'h0020);
        chk("single_gnt", int'(gnt), 16'h0020);
        chk("single_idx", int'(gnt_idx), 5);
        cyc(0, 16'h0020);
        cyc(0, 16'h0020);
        chk("single_hold", int'(gnt), 16'h0020);
        cyc(0, 16'h0000);
        chk("single_drop", int'(gnt), 0);

        cyc(1, 16'h0000);
        cyc(0, 16'h8001);
        chk("cont_first", int'(gnt_idx), 0);
        cyc(0, 16'h8000);
        chk("cont_next", int'(gnt), 16'h8000);
        chk("cont_nogap", int'(gnt_valid), 1);
        cyc(0, 16'h0000);
        chk("cont_idle", int'(gnt_valid), 0);
        cyc(0, 16'h0003);
        chk("wrap_ptr", int'(gnt_idx), 0);
        cyc(0, 16'h0000);

        cyc(1, 16'h0000);
        for (int k = 1; k <= 9; k++) begin
            cyc(0, 16'h0088);
            chk("timeout_idx", int'(gnt_idx), (k <= 4) ? 3 : (k <= 8) ? 7 : 3);
        end

        cyc(1, 16'h0000);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 16'h0200);
            chk("hog_gnt", int'(gnt), 16'h0200);
            chk("hog_valid", int'(gnt_valid), 1);
            chk("hog_cnt", int'(dut.hold_cnt), (k - 1) % 4);
        end

        cyc(1, 16'h0000);
        cyc(0, 16'h0200);
        cyc(0, 16'h0200);
        chk("mid_owner", int'(gnt_idx), 9);
        cyc(1, 16'h0200);
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_valid", int'(gnt_valid), 0);
        chk("mid_rst_idx", int'(gnt_idx), 0);
        cyc(0, 16'h0201);
        chk("mid_after", int'(gnt_idx), 0);

        for (int k = 0; k < 3000; k++) begin
            logic [15:0] q;
            case ($urandom_range(0, 3))
                0: q = 16'h0000;
                1: q = 16'(1) << $urandom_range(0, 15);
                2: q = 16'($urandom) & 16'($urandom);
                default: q = 16'($urandom);
            endcase
            cyc($urandom_range(0, 199) == 0, q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
